// File: rtl/s9_actividad1_if.sv
// Bus between the board switches/button and the calculator outputs (display and LEDs).
// The master drives the user inputs; the slave is the calculator.
interface s9_actividad1_if;
  logic        Enter;
  logic [15:0] DataIn;
  logic [15:0] ToDisplay;
  logic [4:0]  Flags;
  logic [2:0]  Status;

  modport master (
    output Enter,
    output DataIn,
    input  ToDisplay,
    input  Flags,
    input  Status
  );

  modport slave (
    input  Enter,
    input  DataIn,
    output ToDisplay,
    output Flags,
    output Status
  );
endinterface

// File: rtl/s9_actividad1.sv
// Four-step 16-bit calculator: latch A, B and an opcode on successive Enter presses,
// then show the ALU result and its {N,Z,C,V,P} flags until the next press.
module s9_actividad1 (
  input  logic             clk,
  input  logic             reset,
  s9_actividad1_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_WAIT_B  = 3'd2,
    ST_LOAD_B  = 3'd3,
    ST_WAIT_OP = 3'd4,
    ST_LOAD_OP = 3'd5,
    ST_SHOW    = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_enter_prev;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [1:0]  r_op;

  logic        w_enter_rise;
  logic [15:0] w_b_eff;
  logic [16:0] w_sum;
  logic [15:0] w_result;
  logic        w_c;
  logic        w_v;
  logic        w_n;
  logic        w_z;
  logic        w_p;

  assign w_enter_rise = bus.Enter & ~r_enter_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enter_prev <= 1'b0;
      r_state      <= ST_WAIT_A;
    end else begin
      r_enter_prev <= bus.Enter;
      r_state      <= w_state_next;
    end
  end

  // Load states advance unconditionally, so presses during them are dropped.
  always_comb begin
    w_state_next = ST_WAIT_A;
    case (r_state)
      ST_WAIT_A:  w_state_next = w_enter_rise ? ST_LOAD_A : ST_WAIT_A;
      ST_LOAD_A:  w_state_next = ST_WAIT_B;
      ST_WAIT_B:  w_state_next = w_enter_rise ? ST_LOAD_B : ST_WAIT_B;
      ST_LOAD_B:  w_state_next = ST_WAIT_OP;
      ST_WAIT_OP: w_state_next = w_enter_rise ? ST_LOAD_OP : ST_WAIT_OP;
      ST_LOAD_OP: w_state_next = ST_SHOW;
      ST_SHOW:    w_state_next = w_enter_rise ? ST_WAIT_A : ST_SHOW;
      default:    w_state_next = ST_WAIT_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a  <= 16'h0000;
      r_b  <= 16'h0000;
      r_op <= 2'b00;
    end else begin
      case (r_state)
        ST_LOAD_A:  r_a  <= bus.DataIn;
        ST_LOAD_B:  r_b  <= bus.DataIn;
        ST_LOAD_OP: r_op <= bus.DataIn[1:0];
        ST_SHOW: begin
          if (w_enter_rise) begin
            r_a  <= 16'h0000;
            r_b  <= 16'h0000;
            r_op <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  // Subtraction reuses the adder as A + ~B + 1, so C means "no borrow".
  assign w_b_eff = r_op[0] ? ~r_b : r_b;
  assign w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {16'h0000, r_op[0]};

  always_comb begin
    w_result = 16'h0000;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (r_op)
      2'b00, 2'b01: begin
        w_result = w_sum[15:0];
        w_c      = w_sum[16];
        w_v      = (r_a[15] == w_b_eff[15]) && (w_sum[15] != r_a[15]);
      end
      2'b10:   w_result = r_a | r_b;
      default: w_result = r_a & r_b;
    endcase
  end

  assign w_n = w_result[15];
  assign w_z = (w_result == 16'h0000);
  assign w_p = ^w_result;

  always_comb begin
    bus.ToDisplay = bus.DataIn;
    bus.Flags     = 5'b00000;
    case (r_state)
      ST_WAIT_A,
      ST_WAIT_B:  bus.ToDisplay = bus.DataIn;
      ST_WAIT_OP: bus.ToDisplay = {14'h0000, bus.DataIn[1:0]};
      ST_LOAD_A:  bus.ToDisplay = r_a;
      ST_LOAD_B:  bus.ToDisplay = r_b;
      ST_LOAD_OP: bus.ToDisplay = {14'h0000, r_op};
      ST_SHOW: begin
        bus.ToDisplay = w_result;
        bus.Flags     = {w_n, w_z, w_c, w_v, w_p};
      end
      default:    bus.ToDisplay = bus.DataIn;
    endcase
  end

  assign bus.Status = r_state;

endmodule

// File: tb/tb_s9_actividad1.sv
// Bench for s9_actividad1: directed calculations queued on a scoreboard and
// checked by a monitor when the result screen appears, plus press/reset checks.
module tb_s9_actividad1;

  typedef struct {
    string       name;
    logic [15:0] r;
    logic [4:0]  f;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  logic [2:0] prev_status = 3'd0;

  s9_actividad1_if bus ();

  s9_actividad1 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a fresh entry into the result screen is the DUT's "output valid".
  always @(negedge clk) begin
    if (reset) begin
      prev_status <= 3'd0;
    end else begin
      if (bus.Status == 3'd6 && prev_status != 3'd6) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_show", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("result %s: ToDisplay=0x%04h Flags=%05b (exp 0x%04h %05b)",
                   e.name, bus.ToDisplay, bus.Flags, e.r, e.f);
          chk({e.name, "_display"}, {16'h0, bus.ToDisplay}, {16'h0, e.r});
          chk({e.name, "_flags"}, {27'h0, bus.Flags}, {27'h0, e.f});
        end
      end
      prev_status <= bus.Status;
    end
  end

  // Enter held across one rising edge, DataIn kept through the load edge.
  task automatic press(input logic [15:0] v);
    @(negedge clk);
    bus.DataIn = v;
    bus.Enter  = 1'b1;
    @(negedge clk);
    bus.Enter  = 1'b0;
    @(negedge clk);
  endtask

  task automatic calc(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] op, input logic [15:0] er, input logic [4:0] ef);
    exp_t e;
    if (bus.Status == 3'd6) press(16'h0000);
    e.name = name;
    e.r    = er;
    e.f    = ef;
    sb_q.push_back(e);
    press(a);
    press(b);
    press({14'h0, op});
    @(negedge clk);
  endtask

  initial begin
    bus.Enter  = 1'b0;
    bus.DataIn = 16'hBEEF;
    reset      = 1'b1;
    #1;
    chk("reset_status", {29'h0, bus.Status}, 32'd0);
    chk("reset_flags", {27'h0, bus.Flags}, 32'd0);
    chk("reset_display", {16'h0, bus.ToDisplay}, 32'h0000BEEF);
    @(negedge clk);
    reset = 1'b0;

    calc("add_3f_12", 16'h003F, 16'h0012, 2'd0, 16'h0051, 5'b00001);
    chk("show_status", {29'h0, bus.Status}, 32'd6);
    calc("add_2a_7b", 16'h002A, 16'h007B, 2'd0, 16'h00A5, 5'b00000);
    calc("add_8000_8000", 16'h8000, 16'h8000, 2'd0, 16'h0000, 5'b01110);
    calc("sub_5_7", 16'h0005, 16'h0007, 2'd1, 16'hFFFE, 5'b10001);
    calc("or_f0_f0f", 16'h00F0, 16'h0F0F, 2'd2, 16'h0FFF, 5'b00000);
    calc("and_f0_f0f", 16'h00F0, 16'h0F0F, 2'd3, 16'h0000, 5'b01000);

    // Leave SHOW, then hold Enter for five edges: only one transition expected.
    press(16'h0000);
    chk("back_to_wait_a", {29'h0, bus.Status}, 32'd0);
    @(negedge clk);
    bus.DataIn = 16'h1111;
    bus.Enter  = 1'b1;
    repeat (5) @(negedge clk);
    bus.Enter  = 1'b0;
    @(negedge clk);
    $display("hold enter: Status=%0d", bus.Status);
    chk("hold_status", {29'h0, bus.Status}, 32'd2);
    bus.DataIn = 16'h2222;
    #1;
    chk("wait_b_live_display", {16'h0, bus.ToDisplay}, 32'h00002222);

    press(16'h3333);
    chk("wait_op_status", {29'h0, bus.Status}, 32'd4);
    chk("wait_op_display", {16'h0, bus.ToDisplay}, 32'h00000003);

    // Asynchronous reset mid-sequence, away from any clock edge.
    #2;
    reset = 1'b1;
    #1;
    $display("reset in WAIT_OP: Status=%0d Flags=%05b", bus.Status, bus.Flags);
    chk("midreset_status", {29'h0, bus.Status}, 32'd0);
    chk("midreset_flags", {27'h0, bus.Flags}, 32'd0);
    chk("midreset_display", {16'h0, bus.ToDisplay}, 32'h00003333);
    @(negedge clk);
    reset = 1'b0;

    calc("sub_1234_1", 16'h1234, 16'h0001, 2'd1, 16'h1233, 5'b00100);
    calc("add_fresh", 16'h7FFF, 16'h0001, 2'd0, 16'h8000, 5'b10011);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
